rv_writeback: RTL and testbench
===============================

# rv_writeback

Writeback (WB) stage of the RV32I five-stage pipeline; the writer side of the decode-stage register file. Consumes EX/MEM results, aligns and sign-extends load data, selects the write value per opcode, and drives the MEM/WB register pair `mem_wb_ir`/`mem_wb_out`. The decode stage writes `regfile[mem_wb_ir[11:7]]` whenever that field is nonzero, so this block clears rd for every non-writing instruction and bubble. A small FSM stalls the pipeline while a load response is outstanding, with a watchdog timeout.

## Interface
- `LOAD_TIMEOUT`, 15, stall cycles allowed for a load response before fault; legal range 1..255.
- `clk` in 1 — pipeline clock.
- `rst` in 1 — asynchronous, active-low reset.
- `ex_mem_valid` in 1 — EX/MEM holds a real instruction (0 = bubble).
- `ex_mem_ir` in 32 — instruction word.
- `ex_mem_pc` in 32 — instruction PC.
- `ex_mem_alu` in 32 — ALU result; load/store byte address for memory ops.
- `dmem_rdata` in 32 — data-memory read word (word-aligned).
- `dmem_rvalid` in 1 — `dmem_rdata` valid this cycle.
- `mem_wb_ir` out 32 — retired instruction, rd cleared when no write.
- `mem_wb_out` out 32 — register write value.
- `wb_stall` out 1 — combinational; upstream must hold all `ex_mem_*` stable while high.
- `load_fault` out 1 — registered one-cycle pulse on load timeout.
- `instret` out 64 — retired-instruction count (see Configuration).

## Operation
- Write value by opcode `ir[6:0]`:
  - LUI 0110111 → `{ir[31:12],12'h000}`.
  - AUIPC 0010111, OP 0110011, OP-IMM 0010011 → `ex_mem_alu`.
  - JAL 1101111, JALR 1100111 → `ex_mem_pc + 4`, mod 2^32.
  - LOAD 0000011 → aligned `dmem_rdata`, selected by funct3 `ir[14:12]`:
    - LB 000 / LBU 100: byte `alu[1:0]`, sign-/zero-extended.
    - LH 001 / LHU 101: half `alu[1]`; `alu[0]` ignored.
    - LW 010: full word; `alu[1:0]` ignored.
- No-write instructions: STORE, BRANCH, unknown opcodes, and LOADs with funct3 011/110/111. Retire with `ir[11:7]` forced to 0 and `mem_wb_out` = 0.
- Bubble (`ex_mem_valid`=0), or any cycle with `wb_stall`=1: `mem_wb_ir` ← 32'h0000_0013, `mem_wb_out` ← 0.
- FSM states IDLE and WAIT, plus an 8-bit counter `cnt`:
  - IDLE, valid LOAD, `dmem_rvalid`=1: retire at this edge; stay IDLE.
  - IDLE, valid LOAD, `dmem_rvalid`=0: `wb_stall`=1; go to WAIT with `cnt`=0.
  - WAIT, `dmem_rvalid`=1: `wb_stall`=0; retire the load; go to IDLE.
  - WAIT, no rvalid, `cnt` < LOAD_TIMEOUT-1: `wb_stall`=1; `cnt`++.
  - WAIT, no rvalid, `cnt` = LOAD_TIMEOUT-1: `wb_stall`=0; retire as no-write; `load_fault` ← 1 for one cycle; go to IDLE.
- `dmem_rvalid` is ignored unless a valid LOAD is presented.
- `ex_mem_valid` dropping during WAIT is a protocol violation; behaviour is unspecified.

## Timing
- Reset (asynchronous, `rst`=0): `mem_wb_ir`=32'h0000_0013, `mem_wb_out`=0, `load_fault`=0, `instret`=0, state IDLE, `cnt`=0. `wb_stall` is 0 while in reset.
- Reset mid-WAIT abandons the load; nothing retires and no fault is raised.
- Non-load latency: 1 cycle from `ex_mem_*` to `mem_wb_*`.
- Load latency: `mem_wb_*` update at the edge where `dmem_rvalid`=1 is sampled.
- Timeout: `wb_stall` stays high for exactly LOAD_TIMEOUT cycles. Fault retire and `load_fault` appear at the following edge.
- `wb_stall` depends combinationally only on state, `cnt`, `ex_mem_valid`, `ex_mem_ir[6:0]`, and `dmem_rvalid`.

## Configuration
- `RV_WB_INSTRET_EN` defined: `instret` increments by 1 at every edge that retires a valid instruction. This includes no-write instructions and timed-out loads; it excludes bubbles and stall cycles. The counter wraps at 2^64.
- `RV_WB_INSTRET_EN` undefined: the counter is not built and `instret` is tied to 64'h0.

## Test plan
- Reset with `rst`=0 mid-stream → `mem_wb_ir`=32'h0000_0013, `mem_wb_out`=0, `wb_stall`=0, `instret`=0.
- JAL x1 at PC 0x100 → `mem_wb_out`=0x104 and rd=1 after 1 cycle. LUI x5, 0xABCDE → `mem_wb_out`=0xABCDE000.
- LB x3 at `alu`=0x2003 with `dmem_rdata`=0x80FF_1234 and rvalid same cycle → `mem_wb_out`=0xFFFF_FF80. Same access with LBU → 0x0000_0080. LH at `alu`=0x2 → 0xFFFF_80FF.
- SW with `ir[11:7]`=5'h0A → `mem_wb_ir[11:7]`=0 and `mem_wb_out`=0; `instret` +1 when the macro is defined.
- LW with rvalid 3 cycles late (LOAD_TIMEOUT=15) → `wb_stall` high 3 cycles; `mem_wb_out`=`dmem_rdata` one edge after rvalid; `load_fault` stays 0.
- LW with no rvalid (LOAD_TIMEOUT=4) → `wb_stall` high exactly 4 cycles; then rd cleared, `load_fault` pulses 1 cycle, FSM returns to IDLE.

Source files
------------

// File: rtl/rv_writeback.sv
// rv_writeback: RV32I writeback stage, writer side of the decode register file.
// Aligns/extends load data, selects the write value by opcode, and produces the
// MEM/WB register pair. A small FSM stalls upstream while a load response is
// outstanding and raises load_fault_o if none arrives within LOAD_TIMEOUT cycles.
// Optional feature: define RV_WB_INSTRET_EN to build the retired-instruction
// counter; otherwise instret_o is tied to zero.
//
// state | meaning
// IDLE  | no load outstanding; loads with an immediate response retire directly
// WAIT  | load presented, response pending; cnt_q counts extra stall cycles
module rv_writeback #(
  parameter int unsigned LOAD_TIMEOUT = 15  // legal range 1..255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_mem_valid_i,
  input  logic [31:0] ex_mem_ir_i,
  input  logic [31:0] ex_mem_pc_i,
  input  logic [31:0] ex_mem_alu_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_rvalid_i,
  output logic [31:0] mem_wb_ir_o,
  output logic [31:0] mem_wb_out_o,
  output logic        wb_stall_o,
  output logic        load_fault_o,
  output logic [63:0] instret_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] out_q, out_d;
  logic        fault_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        wr_en;
  logic [31:0] wr_val;
  logic        stall;
  logic        timeout;
  logic        retire;
  logic        keep_rd;

  assign opcode  = ex_mem_ir_i[6:0];
  assign funct3  = ex_mem_ir_i[14:12];
  assign is_load = ex_mem_valid_i && (opcode == OPC_LOAD);

  // Pick the addressed byte/half out of the word-aligned read data
  always_comb begin
    ld_byte = 8'h00;
    case (ex_mem_alu_i[1:0])
      2'd0: ld_byte = dmem_rdata_i[7:0];
      2'd1: ld_byte = dmem_rdata_i[15:8];
      2'd2: ld_byte = dmem_rdata_i[23:16];
      2'd3: ld_byte = dmem_rdata_i[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = ex_mem_alu_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  end

  // Select the register write value and whether the instruction writes rd at all
  always_comb begin
    wr_en  = 1'b0;
    wr_val = 32'h0;
    case (opcode)
      OPC_LUI: begin
        wr_en  = 1'b1;
        wr_val = {ex_mem_ir_i[31:12], 12'h000};
      end
      OPC_AUIPC, OPC_OP, OPC_OPIMM: begin
        wr_en  = 1'b1;
        wr_val = ex_mem_alu_i;
      end
      OPC_JAL, OPC_JALR: begin
        wr_en  = 1'b1;
        wr_val = ex_mem_pc_i + 32'd4;
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000: begin wr_en = 1'b1; wr_val = {{24{ld_byte[7]}}, ld_byte}; end
          3'b100: begin wr_en = 1'b1; wr_val = {24'h0, ld_byte}; end
          3'b001: begin wr_en = 1'b1; wr_val = {{16{ld_half[15]}}, ld_half}; end
          3'b101: begin wr_en = 1'b1; wr_val = {16'h0, ld_half}; end
          3'b010: begin wr_en = 1'b1; wr_val = dmem_rdata_i; end
          default: begin wr_en = 1'b0; wr_val = 32'h0; end
        endcase
      end
      default: begin
        wr_en  = 1'b0;
        wr_val = 32'h0;
      end
    endcase
  end

  // Load-wait FSM: stall while the response is missing, time out after LOAD_TIMEOUT stall cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load && !dmem_rvalid_i) begin
          stall   = 1'b1;
          state_d = WAIT;
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = IDLE;
        end else if (cnt_q >= TMO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Retire path: bubbles and stalls become NOPs; non-writers keep the word but lose rd
  always_comb begin
    retire  = ex_mem_valid_i && !stall;
    keep_rd = retire && wr_en && !timeout;
    if (!retire) begin
      ir_d = NOP;
    end else if (keep_rd) begin
      ir_d = ex_mem_ir_i;
    end else begin
      ir_d = {ex_mem_ir_i[31:12], 5'd0, ex_mem_ir_i[6:0]};
    end
    out_d = keep_rd ? wr_val : 32'h0;
  end

  // Pipeline register and FSM state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ir_q    <= NOP;
      out_q   <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      out_q   <= out_d;
      fault_q <= timeout;
    end
  end

  assign mem_wb_ir_o  = ir_q;
  assign mem_wb_out_o = out_q;
  assign load_fault_o = fault_q;
  // Gate with reset so a load sitting at the input cannot stall upstream during reset
  assign wb_stall_o   = rst_ni & stall;

`ifdef RV_WB_INSTRET_EN
  logic [63:0] instret_q;

  // Count every retiring valid instruction, including non-writers and timed-out loads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= 64'h0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = 64'h0;
`endif

endmodule

// File: tb/tb_rv_writeback.sv
// Directed bench for rv_writeback: a vector table for single-cycle retires plus
// hand-written sequences for late load responses, timeout and reset mid-wait.
module tb_rv_writeback;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] ir, pc, alu, rdata;
  logic        rvalid;

  logic [31:0] wb_ir, wb_out, wb_ir4, wb_out4;
  logic        stall, fault, stall4, fault4;
  logic [63:0] instret, instret4;

  int tests = 0;
  int fails = 0;
  longint unsigned exp_instret = 0;

  rv_writeback #(.LOAD_TIMEOUT(15)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .ex_mem_valid_i(valid), .ex_mem_ir_i(ir),
    .ex_mem_pc_i(pc), .ex_mem_alu_i(alu), .dmem_rdata_i(rdata), .dmem_rvalid_i(rvalid),
    .mem_wb_ir_o(wb_ir), .mem_wb_out_o(wb_out), .wb_stall_o(stall),
    .load_fault_o(fault), .instret_o(instret)
  );

  rv_writeback #(.LOAD_TIMEOUT(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .ex_mem_valid_i(valid), .ex_mem_ir_i(ir),
    .ex_mem_pc_i(pc), .ex_mem_alu_i(alu), .dmem_rdata_i(rdata), .dmem_rvalid_i(rvalid),
    .mem_wb_ir_o(wb_ir4), .mem_wb_out_o(wb_out4), .wb_stall_o(stall4),
    .load_fault_o(fault4), .instret_o(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] exp_ir;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_instret(input string name);
`ifdef RV_WB_INSTRET_EN
    chk(name, instret, exp_instret);
`else
    chk(name, instret, 64'h0);
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] d, input logic rv);
    valid = v; ir = i; pc = p; alu = a; rdata = d; rvalid = rv;
  endtask

  task automatic add(input string n, input logic v, input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] a, input logic [31:0] d, input logic rv,
                     input logic [31:0] ei, input logic [31:0] eo);
    vec_t t;
    t.name = n; t.valid = v; t.ir = i; t.pc = p; t.alu = a; t.rdata = d; t.rvalid = rv;
    t.exp_ir = ei; t.exp_out = eo;
    vecs.push_back(t);
  endtask

  initial begin
    int n;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    //        name        v   ir            pc            alu           rdata         rv    exp_ir        exp_out
    add("jal_x1",       1, 32'h0000_00EF, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0000_00EF, 32'h0000_0104);
    add("lui_x5",       1, 32'hABCD_E2B7, 32'h0,        32'h0,        32'h0,        0, 32'hABCD_E2B7, 32'hABCD_E000);
    add("addi_x2",      1, 32'h0050_0113, 32'h0,        32'h0000_0055, 32'h0,        1, 32'h0050_0113, 32'h0000_0055);
    add("add_x3",       1, 32'h0020_81B3, 32'h0,        32'hDEAD_BEEF, 32'h0,        0, 32'h0020_81B3, 32'hDEAD_BEEF);
    add("auipc_x4",     1, 32'h0000_1217, 32'h0000_1000, 32'h0000_1100, 32'h0,       0, 32'h0000_1217, 32'h0000_1100);
    add("jalr_wrap",    1, 32'h0000_80E7, 32'hFFFF_FFFC, 32'h0,        32'h0,        0, 32'h0000_80E7, 32'h0000_0000);
    add("lb_b3",        1, 32'h0000_0183, 32'h0,        32'h0000_2003, 32'h80FF_1234, 1, 32'h0000_0183, 32'hFFFF_FF80);
    add("lbu_b3",       1, 32'h0000_4183, 32'h0,        32'h0000_2003, 32'h80FF_1234, 1, 32'h0000_4183, 32'h0000_0080);
    add("lb_b1",        1, 32'h0000_0183, 32'h0,        32'h0000_2001, 32'h80FF_1234, 1, 32'h0000_0183, 32'h0000_0012);
    add("lh_h1",        1, 32'h0000_1183, 32'h0,        32'h0000_0002, 32'h80FF_1234, 1, 32'h0000_1183, 32'hFFFF_80FF);
    add("lhu_odd",      1, 32'h0000_5183, 32'h0,        32'h0000_0003, 32'h80FF_1234, 1, 32'h0000_5183, 32'h0000_80FF);
    add("lh_h0",        1, 32'h0000_1183, 32'h0,        32'h0000_0001, 32'h80FF_9234, 1, 32'h0000_1183, 32'hFFFF_9234);
    add("lw_unalign",   1, 32'h0000_2183, 32'h0,        32'h0000_2003, 32'h80FF_1234, 1, 32'h0000_2183, 32'h80FF_1234);
    add("sw_rd_clr",    1, 32'h0000_2523, 32'h0,        32'h0000_0040, 32'h0,        0, 32'h0000_2023, 32'h0000_0000);
    add("beq_rd_clr",   1, 32'h0000_0463, 32'h0,        32'h0000_0001, 32'h0,        0, 32'h0000_0063, 32'h0000_0000);
    add("ld_f3_011",    1, 32'h0000_3183, 32'h0,        32'h0000_0000, 32'h1234_5678, 1, 32'h0000_3003, 32'h0000_0000);
    add("ld_f3_111",    1, 32'h0000_7183, 32'h0,        32'h0000_0000, 32'h1234_5678, 1, 32'h0000_7003, 32'h0000_0000);
    add("unk_opc",      1, 32'h0000_03FF, 32'h0,        32'h0000_0077, 32'h0,        0, 32'h0000_007F, 32'h0000_0000);
    add("bubble",       0, 32'h0000_00EF, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0000_0013, 32'h0000_0000);
    add("bubble_load",  0, 32'h0000_0183, 32'h0,        32'h0,        32'h0,        0, 32'h0000_0013, 32'h0000_0000);

    // Reset, with a pending load presented at the input
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_2303, 32'h0, 32'h40, 32'h0, 1'b0);
    #12;
    chk("rst_ir",      wb_ir,   32'h0000_0013);
    chk("rst_out",     wb_out,  32'h0);
    chk("rst_stall",   stall,   1'b0);
    chk("rst_fault",   fault,   1'b0);
    chk_instret("rst_instret");
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle vectors
    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].ir, vecs[k].pc, vecs[k].alu, vecs[k].rdata, vecs[k].rvalid);
      #1;
      chk({vecs[k].name, "_stall"}, stall, 1'b0);
      @(posedge clk); #1;
      if (vecs[k].valid) exp_instret++;
      chk({vecs[k].name, "_ir"},  wb_ir,  vecs[k].exp_ir);
      chk({vecs[k].name, "_out"}, wb_out, vecs[k].exp_out);
      chk({vecs[k].name, "_fault"}, fault, 1'b0);
    end
    chk_instret("table_instret");

    // LW with the response arriving 3 cycles late
    drive(1'b1, 32'h0000_2303, 32'h0, 32'h0000_0040, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rvalid = (i == 3);
      rdata  = (i == 3) ? 32'h1122_3344 : 32'hDEAD_0000;
      #1;
      chk($sformatf("late_stall%0d", i), stall, (i < 3) ? 1'b1 : 1'b0);
      chk($sformatf("late_stall4_%0d", i), stall4, (i < 3) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      if (i < 3) begin
        chk($sformatf("late_nop%0d", i), wb_ir, 32'h0000_0013);
        chk_instret($sformatf("late_instret%0d", i));
      end
    end
    exp_instret++;
    chk("late_ir",     wb_ir,   32'h0000_2303);
    chk("late_out",    wb_out,  32'h1122_3344);
    chk("late_fault",  fault,   1'b0);
    chk("late_fault4", fault4,  1'b0);
    chk("late_out4",   wb_out4, 32'h1122_3344);
    chk_instret("late_instret");

    // LW with no response: LOAD_TIMEOUT=4 instance times out
    drive(1'b1, 32'h0000_2303, 32'h0, 32'h0000_0040, 32'h0, 1'b0);
    #1;
    n = 0;
    while (stall4 && n < 20) begin
      n++;
      chk("tmo_fault_early", fault4, 1'b0);
      @(posedge clk); #2;
    end
    chk("tmo_stall_cycles", n, 4);
    @(posedge clk); #1;
    chk("tmo_ir",    wb_ir4,  32'h0000_2003);
    chk("tmo_out",   wb_out4, 32'h0);
    chk("tmo_fault", fault4,  1'b1);
    chk("tmo_long_stall", stall, 1'b1);
    drive(1'b1, 32'h0000_00EF, 32'h0000_0200, 32'h0, 32'h0, 1'b0);
    #1;
    chk("tmo_idle_stall", stall4, 1'b0);
    @(posedge clk); #1;
    chk("tmo_fault_clr", fault4,  1'b0);
    chk("tmo_next_out",  wb_out4, 32'h0000_0204);

    // u_dut (timeout 15) is still in WAIT: reset abandons the load
    drive(1'b1, 32'h0000_2303, 32'h0, 32'h0000_0040, 32'h0, 1'b0);
    #3;
    rst_n = 1'b0;
    exp_instret = 0;
    #1;
    chk("rstw_ir",    wb_ir,  32'h0000_0013);
    chk("rstw_out",   wb_out, 32'h0);
    chk("rstw_stall", stall,  1'b0);
    chk("rstw_fault", fault,  1'b0);
    chk_instret("rstw_instret");
    @(posedge clk); #1;
    chk("rstw_fault_hold", fault, 1'b0);
    drive(1'b1, 32'h0000_00EF, 32'h0000_0100, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    exp_instret++;
    chk("post_rst_out",   wb_out, 32'h0000_0104);
    chk("post_rst_fault", fault,  1'b0);
    chk_instret("post_rst_instret");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
